// File: rtl/sensor_mon_pkg.sv
// Shared types and helpers for the sensor monitor.
//   state_t      : monitor FSM states (IDLE, PEND, ERROR)
//   DEF_*_MASK   : default masks reproducing the original lab-2 rule
//                  "bit 0, or bit 1 together with bit 2 or bit 3"
//   fault_rule() : raw fault evaluation of a sensor vector against the masks
package sensor_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ERROR
  } state_t;

  // Widest sensor vector the rule helper accepts; narrower vectors are
  // zero-extended by the caller.
  localparam int MAX_SENSORS = 32;

  localparam logic [3:0] DEF_CRIT_MASK = 4'b0001;
  localparam logic [3:0] DEF_PRIM_MASK = 4'b0010;
  localparam logic [3:0] DEF_SEC_MASK  = 4'b1100;

  // A vector faults if any critical sensor is set, or if at least one primary
  // and at least one secondary sensor are set together.
  function automatic logic fault_rule(
    input logic [MAX_SENSORS-1:0] vec,
    input logic [MAX_SENSORS-1:0] crit,
    input logic [MAX_SENSORS-1:0] prim,
    input logic [MAX_SENSORS-1:0] sec
  );
    return (|(vec & crit)) | ((|(vec & prim)) & (|(vec & sec)));
  endfunction

endpackage

// File: rtl/sensor_fault_decode.sv
// Combinational fault-rule decoder.
//   vec : sensor vector to evaluate (NUM_SENSORS bits)
//   raw : 1 when the vector matches the mask-configured fault rule
module sensor_fault_decode
  import sensor_mon_pkg::*;
#(
  parameter int                     NUM_SENSORS = 4,
  parameter logic [NUM_SENSORS-1:0] CRIT_MASK   = NUM_SENSORS'(DEF_CRIT_MASK),
  parameter logic [NUM_SENSORS-1:0] PRIM_MASK   = NUM_SENSORS'(DEF_PRIM_MASK),
  parameter logic [NUM_SENSORS-1:0] SEC_MASK    = NUM_SENSORS'(DEF_SEC_MASK)
) (
  input  logic [NUM_SENSORS-1:0] vec,
  output logic                   raw
);

  assign raw = fault_rule(MAX_SENSORS'(vec),
                          MAX_SENSORS'(CRIT_MASK),
                          MAX_SENSORS'(PRIM_MASK),
                          MAX_SENSORS'(SEC_MASK));

endmodule

// File: rtl/sensor_monitor.sv
// Clocked sensor fault monitor with persistence filter and sticky error.
//   clk           : system clock, all state on the rising edge
//   rst           : synchronous active-high reset
//   sensors       : sensor inputs, registered every edge
//   clear_req     : request to clear a latched error
//   error         : sticky qualified error (high while in ERROR)
//   raw_fault     : fault rule evaluated on the registered sensors
//   clear_ack     : one-cycle pulse after an accepted clear
//   fault_sensors : registered sensors captured at the latest ERROR entry
//   fault_count   : number of ERROR entries, saturating
module sensor_monitor
  import sensor_mon_pkg::*;
#(
  parameter int                     NUM_SENSORS = 4,
  parameter logic [NUM_SENSORS-1:0] CRIT_MASK   = NUM_SENSORS'(DEF_CRIT_MASK),
  parameter logic [NUM_SENSORS-1:0] PRIM_MASK   = NUM_SENSORS'(DEF_PRIM_MASK),
  parameter logic [NUM_SENSORS-1:0] SEC_MASK    = NUM_SENSORS'(DEF_SEC_MASK),
  parameter int                     PERSIST     = 3,
  parameter int                     CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic                   clear_req,
  output logic                   error,
  output logic                   raw_fault,
  output logic                   clear_ack,
  output logic [NUM_SENSORS-1:0] fault_sensors,
  output logic [CNT_W-1:0]       fault_count
);

  localparam int               PW        = $clog2(PERSIST + 1);
  localparam logic [PW-1:0]    CNT_LAST  = PW'(PERSIST - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  state_t                   state, state_n;
  logic [PW-1:0]            cnt, cnt_n;
  logic [NUM_SENSORS-1:0]   sens_q;
  logic                     raw;
  logic                     ack_n;
  logic                     enter_err;

  sensor_fault_decode #(
    .NUM_SENSORS (NUM_SENSORS),
    .CRIT_MASK   (CRIT_MASK),
    .PRIM_MASK   (PRIM_MASK),
    .SEC_MASK    (SEC_MASK)
  ) u_decode (
    .vec (sens_q),
    .raw (raw)
  );

  assign raw_fault = raw;
  assign error     = (state == ERROR);

  // NOTE: every signal driven here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ack_n     = 1'b0;
    enter_err = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (raw) begin
          if (PERSIST == 1) begin
            state_n   = ERROR;
            enter_err = 1'b1;
          end else begin
            state_n = PEND;
            cnt_n   = PW'(1);
          end
        end
      end
      PEND: begin
        if (!raw) begin
          // Any dropout restarts qualification from zero.
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = ERROR;
          cnt_n     = '0;
          enter_err = 1'b1;
        end else begin
          cnt_n = cnt + PW'(1);
        end
      end
      ERROR: begin
        // raw is ignored here; only a clear leaves the state.
        if (clear_req) begin
          state_n = IDLE;
          cnt_n   = '0;
          ack_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, e.g. fault_sensors captures the old sens_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      sens_q        <= '0;
      state         <= IDLE;
      cnt           <= '0;
      clear_ack     <= 1'b0;
      fault_sensors <= '0;
      fault_count   <= '0;
    end else begin
      sens_q    <= sensors;
      state     <= state_n;
      cnt       <= cnt_n;
      clear_ack <= ack_n;
      if (enter_err) begin
        fault_sensors <= sens_q;
        if (fault_count != COUNT_MAX) fault_count <= fault_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sensor_monitor.sv
// Scoreboard bench for sensor_monitor. Two instances share one stimulus
// stream: dut_a uses PERSIST=1 / CNT_W=8, dut_b uses PERSIST=3 / CNT_W=2.
// The stimulus process advances a behavioural model per instance and queues
// the expected post-edge outputs; a monitor pops and compares every cycle.
module tb_sensor_monitor;

  typedef struct {
    int err;
    int raw;
    int ack;
    int fsens;
    int fcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sensors = '0;
  logic       clear_req = 1'b0;

  logic       err_a, raw_a, ack_a;
  logic [3:0] fs_a;
  logic [7:0] fc_a;
  logic       err_b, raw_b, ack_b;
  logic [3:0] fs_b;
  logic [1:0] fc_b;

  int n_pass  = 0;
  int n_total = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model state, index 0 = dut_a, 1 = dut_b.
  int       m_streak[2];
  bit       m_err[2];
  bit       m_ack[2];
  logic [3:0] m_sq[2];
  logic [3:0] m_snap[2];
  int       m_cnt[2];

  always #5 clk = ~clk;

  sensor_monitor #(.NUM_SENSORS(4), .PERSIST(1), .CNT_W(8)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .sensors       (sensors),
    .clear_req     (clear_req),
    .error         (err_a),
    .raw_fault     (raw_a),
    .clear_ack     (ack_a),
    .fault_sensors (fs_a),
    .fault_count   (fc_a)
  );

  sensor_monitor #(.NUM_SENSORS(4), .PERSIST(3), .CNT_W(2)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .sensors       (sensors),
    .clear_req     (clear_req),
    .error         (err_b),
    .raw_fault     (raw_b),
    .clear_ack     (ack_b),
    .fault_sensors (fs_b),
    .fault_count   (fc_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Original lab-2 rule written directly on the bits.
  function automatic bit orig_rule(input logic [3:0] s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

  // Model: an error is declared once the fault has been seen on PERSIST
  // consecutive edges outside of an error episode.
  task automatic model_edge(input int d, input logic [3:0] s, input bit clr, input bit r);
    int   persist;
    int   cmax;
    exp_t e;
    persist = (d == 0) ? 1 : 3;
    cmax    = (d == 0) ? 255 : 3;
    if (r) begin
      m_streak[d] = 0;
      m_err[d]    = 1'b0;
      m_ack[d]    = 1'b0;
      m_sq[d]     = '0;
      m_snap[d]   = '0;
      m_cnt[d]    = 0;
    end else begin
      m_ack[d] = 1'b0;
      if (m_err[d]) begin
        if (clr) begin
          m_err[d]    = 1'b0;
          m_ack[d]    = 1'b1;
          m_streak[d] = 0;
        end
      end else begin
        m_streak[d] = orig_rule(m_sq[d]) ? m_streak[d] + 1 : 0;
        if (m_streak[d] == persist) begin
          m_err[d]    = 1'b1;
          m_snap[d]   = m_sq[d];
          m_streak[d] = 0;
          if (m_cnt[d] < cmax) m_cnt[d]++;
        end
      end
      m_sq[d] = s;
    end
    e.err   = int'(m_err[d]);
    e.raw   = int'(orig_rule(m_sq[d]));
    e.ack   = int'(m_ack[d]);
    e.fsens = int'(m_snap[d]);
    e.fcnt  = m_cnt[d];
    if (d == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // Drive one cycle of inputs away from the active edge and queue the
  // expected response for the coming edge.
  task automatic step(input logic [3:0] s, input bit clr, input bit r);
    @(negedge clk);
    sensors   = s;
    clear_req = clr;
    rst       = r;
    model_edge(0, s, clr, r);
    model_edge(1, s, clr, r);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUTs present all outputs; compare against queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a.error", int'(err_a), e.err);
        check("a.raw_fault", int'(raw_a), e.raw);
        check("a.clear_ack", int'(ack_a), e.ack);
        check("a.fault_sensors", int'(fs_a), e.fsens);
        check("a.fault_count", int'(fc_a), e.fcnt);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b.error", int'(err_b), e.err);
        check("b.raw_fault", int'(raw_b), e.raw);
        check("b.clear_ack", int'(ack_b), e.ack);
        check("b.fault_sensors", int'(fs_b), e.fsens);
        check("b.fault_count", int'(fc_b), e.fcnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rule_tbl;
    int          sat_exp[5];
    logic [3:0]  cur;
    rule_tbl = 16'hEEEA;  // fault set: odd vectors plus 0110, 1010, 1110
    sat_exp  = '{1, 2, 3, 3, 3};

    // Reset state.
    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b1);
    after_edge();
    check("reset.error", int'(err_b), 0);
    check("reset.fault_count", int'(fc_b), 0);

    // 1. Exhaustive rule check on dut_a, clearing after each vector.
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 3; k++) step(4'(v), 1'b0, 1'b0);
      after_edge();
      check($sformatf("rule[%0d]", v), int'(raw_a), int'(rule_tbl[v]));
      step(4'h0, 1'b1, 1'b0);
      step(4'h0, 1'b1, 1'b0);
      step(4'h0, 1'b0, 1'b0);
    end

    // 2. Persistence on dut_b.
    step(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      after_edge();
      check($sformatf("persist.error@e%0d", i), int'(err_b), (i == 3) ? 1 : 0);
    end
    check("persist.fault_sensors", int'(fs_b), 1);
    check("persist.fault_count", int'(fc_b), 1);

    // 3. Dropout restarts qualification.
    step(4'h0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    after_edge();
    check("dropout.no_error", int'(err_b), 0);
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      after_edge();
      check($sformatf("dropout.error@e%0d", i), int'(err_b), (i == 3) ? 1 : 0);
    end

    // 4. Clear handshake with the fault still held.
    step(4'b0001, 1'b1, 1'b0);
    after_edge();
    check("clear.error_low", int'(err_b), 0);
    check("clear.ack_high", int'(ack_b), 1);
    step(4'b0001, 1'b1, 1'b0);  // clear_req in IDLE
    after_edge();
    check("clear.ack_once", int'(ack_b), 0);
    step(4'b0001, 1'b0, 1'b0);
    after_edge();
    check("requal.error_e2", int'(err_b), 0);
    step(4'b0001, 1'b0, 1'b0);
    after_edge();
    check("requal.error_e3", int'(err_b), 1);
    check("requal.fault_count", int'(fc_b), 2);

    // 5. Saturation of the 2-bit counter.
    step(4'h0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
      after_edge();
      check($sformatf("sat.count[%0d]", n), int'(fc_b), sat_exp[n]);
      step(4'h0, 1'b1, 1'b0);
      step(4'h0, 1'b0, 1'b0);
    end

    // 6. Reset while pending, then reset together with a clear in ERROR.
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b1);
    after_edge();
    check("rst_pend.raw_fault", int'(raw_b), 0);
    check("rst_pend.fault_count", int'(fc_b), 0);
    for (int i = 0; i < 4; i++) step(4'b1010, 1'b0, 1'b0);
    after_edge();
    check("rst_err.pre_error", int'(err_b), 1);
    step(4'b1010, 1'b1, 1'b1);
    after_edge();
    check("rst_err.error", int'(err_b), 0);
    check("rst_err.ack", int'(ack_b), 0);
    check("rst_err.fault_sensors", int'(fs_b), 0);
    step(4'h0, 1'b0, 1'b0);
    after_edge();
    check("rst_err.no_late_ack", int'(ack_b), 0);

    // 7. Randomised traffic against the model.
    cur = '0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 4'($urandom);
      step(cur, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drain", q_a.size() + q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sensor_monitor.md
# sensor_monitor

Parametrised, clocked successor to the lab-2 sensor error decoder. It registers an N-bit sensor vector and evaluates a mask-configurable fault rule; the default masks reproduce the original "bit 0, or bit 1 with bit 2 or bit 3" rule. A fault must persist for a programmable number of consecutive cycles before a sticky error is raised. The error is held until it is acknowledged through a clear handshake, and the first-fault snapshot and a saturating fault counter are kept for diagnostics.

## Interface
- NUM_SENSORS, default 4: width of the sensor vector (≥ 2).
- CRIT_MASK, default 4'b0001: sensors that fault on their own.
- PRIM_MASK, default 4'b0010: primary sensors of the paired rule.
- SEC_MASK, default 4'b1100: secondary sensors of the paired rule.
- PERSIST, default 3: consecutive raw-fault cycles required to raise error (≥ 1).
- CNT_W, default 8: width of fault_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- sensors  in  NUM_SENSORS  sensor inputs, sampled every edge.
- clear_req  in  1  request to clear a latched error.
- error  out  1  sticky qualified error.
- raw_fault  out  1  fault rule evaluated on the registered sensors.
- clear_ack  out  1  one-cycle pulse confirming an accepted clear.
- fault_sensors  out  NUM_SENSORS  sensor snapshot at the most recent ERROR entry.
- fault_count  out  CNT_W  number of ERROR entries, saturating.

## Operation
- Sampling and fault rule:
  - sens_q <= sensors on every edge.
  - raw = |(sens_q & CRIT_MASK) | ( |(sens_q & PRIM_MASK) & |(sens_q & SEC_MASK) ).
  - raw_fault = raw (combinational from sens_q).
- State machine (states IDLE, PEND, ERROR), with persistence counter cnt of width clog2(PERSIST+1):
  - IDLE:
    - raw & PERSIST==1 -> ERROR.
    - raw -> PEND with cnt=1.
    - otherwise stay, cnt=0.
  - PEND:
    - !raw -> IDLE, cnt=0.
    - raw & cnt==PERSIST-1 -> ERROR.
    - raw -> cnt+1.
  - ERROR:
    - error=1.
    - clear_req -> IDLE, cnt=0, clear_ack=1 for the next cycle.
    - otherwise stay. raw is ignored while in ERROR.
- On every transition into ERROR:
  - fault_sensors <= sens_q.
  - fault_count <= fault_count+1; it holds at 2^CNT_W−1 once saturated.
- clear_req outside ERROR is ignored and produces no clear_ack.
- If raw is still active after a clear, the fault re-qualifies from IDLE. Error re-asserts after a further PERSIST cycles and fault_count increments again.
- fault_count and fault_sensors are cleared only by rst.

## Timing
- Reset values: error=0, clear_ack=0, fault_sensors=0, fault_count=0, sens_q=0 (so raw_fault=0), state=IDLE, cnt=0.
- Qualification latency: sensors applied before edge e0 and held cause error to be high after edge e(PERSIST). That is PERSIST+1 edges from first presentation.
- raw_fault is high after e0.
- A single-cycle dropout of raw while in PEND restarts qualification from zero.
- clear_req sampled high at edge k while in ERROR:
  - error is low after k.
  - clear_ack is high for exactly the one cycle after k.
- clear_req held high continuously gives at most one ack per ERROR episode.
- rst at any edge overrides every other event, including ERROR entry and clear on the same edge. After that edge all outputs are at their reset values.

## Structure
- Package sensor_mon_pkg holds:
  - the state enum typedef (IDLE, PEND, ERROR);
  - the default mask constants;
  - a function fault_rule(vec, crit, prim, sec) returning raw.
- One natural sub-module is sensor_fault_decode: combinational, it implements the fault rule from sens_q and the masks. Used by the monitor and reusable by the bench as a reference model.
- The FSM, counters and snapshot registers live in sensor_monitor.

## Test plan
1. Exhaustive rule check: with PERSIST=1, defaults, apply each of 0–15 held for 3 cycles; raw_fault matches the original rule.
   - 4'b0001, 4'b0110 and 4'b1010 fault; 4'b0010 and 4'b1100 do not.
   - Clear after each error.
2. Persistence: with PERSIST=3, hold 4'b0001.
   - error rises exactly 4 edges after presentation.
   - fault_sensors=4'b0001, fault_count=1.
3. Dropout: with PERSIST=3, apply 4'b0001 for 2 cycles, then 4'b0000 for 1 cycle, then 4'b0001 held.
   - No error after the first two cycles.
   - error rises 4 edges after the second presentation.
4. Clear handshake:
   - In ERROR, pulse clear_req: error falls on the next edge; clear_ack is high for one cycle.
   - clear_req in IDLE gives no ack.
   - With the fault still held, error re-asserts after 3 more edges and fault_count=2.
5. Saturation: with CNT_W=2, run 5 error/clear cycles; fault_count reads 1, 2, 3, 3, 3.
6. Reset mid-operation: assert rst while in PEND and again while in ERROR with clear_req high.
   - All outputs reach reset values after that edge.
   - No clear_ack is produced.
